// File: rtl/mem_responder_if.sv
// Core memory bus plus program loader stream for mem_responder.
// master: core/loader side drives requests; slave: responder answers.
interface mem_responder_if #(
  parameter int WIDTH    = 8,
  parameter int ADDRBITS = 8
);
  logic                memread;
  logic                memwrite;
  logic [ADDRBITS-1:0] adr;
  logic [WIDTH-1:0]    writedata;
  logic [WIDTH-1:0]    memdata;
  logic                ld_valid;
  logic [WIDTH-1:0]    ld_data;
  logic                ld_last;
  logic                ld_ready;
  logic                cpu_reset;
  logic [ADDRBITS:0]   ld_count;
  logic                ld_overflow;

  modport master (
    output memread, memwrite, adr, writedata,
    output ld_valid, ld_data, ld_last,
    input  memdata, ld_ready, cpu_reset,
    input  ld_count, ld_overflow
  );

  modport slave (
    input  memread, memwrite, adr, writedata,
    input  ld_valid, ld_data, ld_last,
    output memdata, ld_ready, cpu_reset,
    output ld_count, ld_overflow
  );
endinterface

// File: rtl/mem_responder.sv
// Byte memory target: zero-fill, load image, then serve the core.
// Ports: clk, reset (sync, active-high), bus (mem_responder_if.slave).
module mem_responder #(
  parameter int WIDTH    = 8,
  parameter int ADDRBITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int DEPTH = 1 << ADDRBITS;
  localparam logic [ADDRBITS-1:0] P_ONE = 1;
  localparam logic [ADDRBITS:0]   C_ONE = 1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDRBITS-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDRBITS-1:0] ld_ptr_q, ld_ptr_d;
  logic [ADDRBITS:0]   ld_count_q, ld_count_d;
  logic                ld_ovf_q, ld_ovf_d;
  logic                cpu_reset_q, cpu_reset_d;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                mem_we;
  logic [ADDRBITS-1:0] mem_waddr;
  logic [WIDTH-1:0]    mem_wdata;

  logic                ld_ready;
  logic [WIDTH-1:0]    memdata;
  logic                full;

  // Count saturates at DEPTH, so its top bit alone flags a full image.
  assign full = ld_count_q[ADDRBITS];

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    ld_ptr_d    = ld_ptr_q;
    ld_count_d  = ld_count_q;
    ld_ovf_d    = ld_ovf_q;
    cpu_reset_d = cpu_reset_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    ld_ready    = 1'b0;
    memdata     = '0;
    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + P_ONE;
        if (&clr_ptr_q) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (bus.ld_valid) begin
          if (!full) begin
            mem_we     = 1'b1;
            mem_waddr  = ld_ptr_q;
            mem_wdata  = bus.ld_data;
            ld_ptr_d   = ld_ptr_q + P_ONE;
            ld_count_d = ld_count_q + C_ONE;
          end else begin
            ld_ovf_d = 1'b1;
          end
          if (bus.ld_last) begin
            state_d     = S_RUN;
            cpu_reset_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        // Read is combinational from the current array, so a
        // same-cycle write shows the old byte.
        if (bus.memread) begin
          memdata = mem_q[bus.adr];
        end
        mem_we    = bus.memwrite;
        mem_waddr = bus.adr;
        mem_wdata = bus.writedata;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      clr_ptr_q   <= '0;
      ld_ptr_q    <= '0;
      ld_count_q  <= '0;
      ld_ovf_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      ld_ptr_q    <= ld_ptr_d;
      ld_count_q  <= ld_count_d;
      ld_ovf_q    <= ld_ovf_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  // Storage has no reset; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.ld_ready    = ld_ready;
  assign bus.memdata     = memdata;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.ld_count    = ld_count_q;
  assign bus.ld_overflow = ld_ovf_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder.
// Reference model: byte array + count/overflow/run flags.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mem_responder_if #(.WIDTH(8), .ADDRBITS(8)) bus ();

  mem_responder #(.WIDTH(8), .ADDRBITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [7:0] m_mem [256];
  int         m_count;
  bit         m_ovf;
  bit         m_run;
  logic [7:0] exp_q [$];
  logic [7:0] img [$];
  logic [7:0] mon_e;
  int         total = 0;
  int         bad = 0;
  int         n;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_last   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.memread === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd: unexpected read, got %0h", bus.memdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd", int'(bus.memdata), int'(mon_e));
      end
    end
  end

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    chk("rst_ld_ready", int'(bus.ld_ready), 0);
    chk("rst_cpu_reset", int'(bus.cpu_reset), 1);
    chk("rst_ld_count", int'(bus.ld_count), 0);
    chk("rst_ld_overflow", int'(bus.ld_overflow), 0);
    chk("rst_memdata", int'(bus.memdata), 0);
    tick();
    reset = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    m_count = 0;
    m_ovf = 1'b0;
    m_run = 1'b0;
  endtask

  // Reads random addresses (all must be 0) until ld_ready rises.
  task automatic wait_clear(input int pulse_at);
    int bad_cr;
    int cyc;
    bad_cr = 0;
    cyc = 0;
    while (bus.ld_ready !== 1'b1 && cyc < 400) begin
      bus.memread  = 1'b1;
      bus.memwrite = 1'b0;
      bus.adr      = 8'($urandom);
      if (cyc == pulse_at || cyc == pulse_at + 1) begin
        bus.adr       = (cyc == pulse_at) ? 8'd3 : 8'd200;
        bus.memwrite  = 1'b1;
        bus.writedata = 8'hFF;
      end
      exp_q.push_back(8'h00);
      if (bus.cpu_reset !== 1'b1) bad_cr++;
      tick();
      cyc++;
    end
    idle();
    chk("clear_len", cyc, 256);
    chk("cpu_reset_in_clear", bad_cr, 0);
  endtask

  task automatic core(input bit rd, input bit wr,
                      input logic [7:0] a, input logic [7:0] wd);
    bus.memread   = rd;
    bus.memwrite  = wr;
    bus.adr       = a;
    bus.writedata = wd;
    if (rd) exp_q.push_back(m_run ? m_mem[a] : 8'h00);
    if (wr && m_run) m_mem[a] = wd;
    tick();
  endtask

  task automatic load(input logic [7:0] im [$], input bit use_last);
    int  tries;
    bit  done;
    bit  is_last;
    bit  cr_before;
    foreach (im[i]) begin
      tries = 0;
      done = 1'b0;
      is_last = use_last && (i == im.size() - 1);
      while (!done) begin
        if (tries > 40) begin
          total++;
          bad++;
          $display("FAIL load_stall: byte %0d not accepted", i);
          idle();
          return;
        end
        bus.ld_valid = (tries >= 6) ? 1'b1 : 1'($urandom);
        bus.ld_data  = im[i];
        bus.ld_last  = bus.ld_valid ? is_last : 1'($urandom);
        cr_before    = bus.cpu_reset;
        if (bus.ld_valid && bus.ld_ready) begin
          done = 1'b1;
          if (m_count < 256) begin
            m_mem[m_count] = im[i];
            m_count++;
          end else begin
            m_ovf = 1'b1;
          end
          if (is_last) m_run = 1'b1;
        end
        tick();
        tries++;
      end
      if (is_last) begin
        idle();
        chk("cpu_reset_fall", int'({cr_before, bus.cpu_reset}), 2);
      end
    end
    idle();
  endtask

  task automatic check_status();
    chk("ld_count", int'(bus.ld_count), m_count);
    chk("ld_overflow", int'(bus.ld_overflow), int'(m_ovf));
    chk("ld_ready_run", int'(bus.ld_ready), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.adr = '0;
    bus.writedata = '0;
    bus.ld_data = '0;

    // Reset sequence, with write pulses ignored during CLEAR.
    do_reset();
    wait_clear(100);
    n = 0;
    for (int c = 0; c < 44; c++) begin
      bus.memread = 1'b1;
      bus.adr = 8'($urandom);
      bus.memwrite = (c == 10);
      if (c == 10) begin
        bus.adr = 8'd100;
        bus.writedata = 8'hFF;
      end
      exp_q.push_back(8'h00);
      if (bus.cpu_reset !== 1'b1 || bus.ld_ready !== 1'b1) n++;
      tick();
    end
    idle();
    chk("load_idle_flags", n, 0);

    // Load and fetch.
    img = {8'h20, 8'h07, 8'h00, 8'h05};
    for (int i = 0; i < 4; i++) img.push_back(8'($urandom));
    load(img, 1'b1);
    check_status();
    for (int a = 0; a < 4; a++) core(1'b1, 1'b0, 8'(a), 8'h00);
    core(1'b1, 1'b0, 8'd8, 8'h00);
    core(1'b1, 1'b0, 8'd100, 8'h00);
    core(1'b1, 1'b0, 8'd200, 8'h00);

    // Core store/load and read-before-write.
    core(1'b0, 1'b1, 8'h80, 8'h5A);
    core(1'b1, 1'b0, 8'h80, 8'h00);
    core(1'b1, 1'b1, 8'h80, 8'hA5);
    core(1'b1, 1'b0, 8'h80, 8'h00);
    for (int k = 0; k < 200; k++) begin
      core(1'($urandom), ($urandom % 3) == 0,
           8'($urandom % 16) ^ 8'h80, 8'($urandom));
    end
    idle();

    // Overflow with the i&0xFF pattern.
    do_reset();
    wait_clear(-10);
    img = {};
    for (int i = 0; i < 258; i++) img.push_back(8'(i));
    load(img, 1'b1);
    check_status();
    core(1'b1, 1'b0, 8'd0, 8'h00);
    core(1'b1, 1'b0, 8'd255, 8'h00);

    // Overflow with random bytes: wrapped bytes must be discarded.
    do_reset();
    wait_clear(-10);
    img = {};
    for (int i = 0; i < 261; i++) img.push_back(8'($urandom));
    load(img, 1'b1);
    check_status();
    for (int a = 0; a < 256; a++) core(1'b1, 1'b0, 8'(a), 8'h00);
    idle();

    // Reset mid-load, then a 1-byte reload.
    do_reset();
    wait_clear(-10);
    img = {};
    for (int i = 0; i < 5; i++) img.push_back(8'($urandom) | 8'h01);
    load(img, 1'b0);
    chk("midload_count", int'(bus.ld_count), 5);
    do_reset();
    wait_clear(-10);
    img = {8'h3C};
    load(img, 1'b1);
    check_status();
    core(1'b1, 1'b0, 8'd0, 8'h00);
    core(1'b1, 1'b0, 8'd2, 8'h00);
    core(1'b1, 1'b0, 8'd4, 8'h00);

    // Requests outside RUN, then image with byte 3 = 0x11.
    do_reset();
    wait_clear(120);
    core(1'b1, 1'b1, 8'd3, 8'hFF);
    core(1'b1, 1'b1, 8'd150, 8'hFF);
    idle();
    img = {8'h01, 8'h02, 8'h03, 8'h11};
    load(img, 1'b1);
    check_status();
    core(1'b1, 1'b0, 8'd3, 8'h00);
    core(1'b1, 1'b0, 8'd150, 8'h00);
    core(1'b1, 1'b0, 8'd200, 8'h00);
    idle();
    tick();
    chk("queue_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-wide memory target for the multicycle core: it answers the core's `memread`/`memwrite`/`adr` byte requests and holds both instruction and data bytes. After reset it zero-fills its storage and then accepts a program image over a valid/ready loader stream. While clearing and loading it holds the core in reset through `cpu_reset`, then releases the core to fetch from address 0.

## Interface
Parameters:
- `WIDTH`, 8, data byte width
- `ADDRBITS`, 8, address width; DEPTH = 2^ADDRBITS entries

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high
- `memread`  in  1  core read request
- `memwrite`  in  1  core write request
- `adr`  in  ADDRBITS  core byte address
- `writedata`  in  WIDTH  core write byte
- `memdata`  out  WIDTH  read byte to core, combinational
- `ld_valid`  in  1  loader byte present
- `ld_data`  in  WIDTH  loader byte
- `ld_last`  in  1  marks final loader byte, qualified by `ld_valid`
- `ld_ready`  out  1  responder accepts a loader byte this cycle
- `cpu_reset`  out  1  registered reset to the core, active-high
- `ld_count`  out  ADDRBITS+1  bytes stored by the loader
- `ld_overflow`  out  1  sticky: image exceeded DEPTH

## Operation
- State machine with three states: CLEAR, LOAD, RUN.
- Reset forces CLEAR and sets clr_ptr=0, ld_ptr=0, `ld_count`=0, `ld_overflow`=0, `cpu_reset`=1. Reset asserted in any state, including mid-load or mid-run, behaves identically: memory is re-zeroed and the image must be reloaded.
- CLEAR:
  - Each cycle writes 0 to mem[clr_ptr] and increments clr_ptr.
  - The cycle that writes DEPTH-1 moves the FSM to LOAD.
  - `ld_ready`=0. Core requests are ignored.
- LOAD:
  - `ld_ready`=1 combinationally. A transfer occurs when `ld_valid`&`ld_ready` at the clock edge.
  - On a transfer with `ld_count`<DEPTH: mem[ld_ptr]<=`ld_data`, ld_ptr increments (wraps to 0 after DEPTH-1), `ld_count`++.
  - On a transfer with `ld_count`==DEPTH: the byte is accepted and discarded, `ld_overflow`<=1, and `ld_count` holds at DEPTH.
  - A transfer with `ld_last`=1 moves the FSM to RUN; that byte is stored under the same rules.
  - `ld_last` without `ld_valid` has no effect.
  - A zero-length image is not possible; at least one byte is required.
- RUN:
  - `ld_ready`=0. Loader inputs are ignored.
  - `memdata` = mem[`adr`] when `memread`=1, else 0.
  - `memwrite`=1 writes mem[`adr`]<=`writedata` at the edge.
  - `memread`&`memwrite` together: the write occurs and `memdata` shows the pre-write byte in that cycle (read-before-write).
  - RUN persists until reset.
- `memdata`=0 in every cycle outside RUN.
- `cpu_reset` is a register: it is 1 in CLEAR and LOAD and falls to 0 on the edge that enters RUN.

## Timing
- CLEAR lasts exactly DEPTH cycles after reset deasserts (256 at default).
- Loader throughput is one byte per cycle with `ld_valid` held high. There are no bubbles.
- Core read has zero latency: `memdata` is valid in the same cycle as `memread`/`adr`. The core latches it at the following edge, matching its 4-cycle byte fetch.
- Core write takes effect at the edge where `memwrite`=1; a read of the same address in the next cycle returns the new byte.
- The first cycle with `cpu_reset`=0 is the first RUN cycle.
- Reset values of all outputs: `memdata`=0, `ld_ready`=0, `cpu_reset`=1, `ld_count`=0, `ld_overflow`=0.

## Test plan
- Reset sequence: deassert reset, then hold `ld_valid`=0 for 300 cycles.
  - `ld_ready` rises exactly 256 cycles after reset deasserts.
  - `cpu_reset` stays 1 throughout.
  - `memdata`=0 throughout.
- Load and fetch: stream 8 bytes 0x20,0x07,0x00,0x05,... with `ld_last` on byte 8, with `ld_valid` toggled randomly.
  - `ld_count`=8.
  - `cpu_reset` falls the cycle after the last transfer.
  - `memread` with `adr`=0..3 returns 0x20,0x07,0x00,0x05.
  - `adr`=8 returns 0x00.
- Core store and load: in RUN, write 0x5A to `adr`=0x80.
  - The next-cycle read of 0x80 returns 0x5A.
  - `memread`&`memwrite` together at 0x80 with `writedata`=0xA5 shows 0x5A that cycle and 0xA5 the next cycle.
- Overflow: load 258 bytes with values i&0xFF, with `ld_last` on the 258th.
  - `ld_count`=256 and `ld_overflow`=1.
  - mem[0]=0x00 and mem[255]=0xFF; mem[0] is not overwritten by byte 256.
- Reset mid-load: assert reset after 5 loader bytes.
  - Outputs return to their reset values.
  - After the new CLEAR completes, address 2 reads 0 following a 1-byte reload.
- Requests outside RUN: pulse `memwrite` at `adr`=3 with `writedata`=0xFF during CLEAR and during LOAD.
  - `memdata` stays 0.
  - After a load with byte 3=0x11, address 3 reads 0x11.
